// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: FIFO geometry (ADDR_SIZE, DEPTH), pointer type ptr_t and the wrapping increment next_ptr
package sync_fifo_pkg;
  localparam int ADDR_SIZE = 4;
  localparam int DEPTH = 2 ** ADDR_SIZE;
  typedef logic [ADDR_SIZE:0] ptr_t;
  function automatic ptr_t next_ptr(input ptr_t p);
    return p + ptr_t'(1);
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: dual-port RAM; ports clk, rst (active-low async), w_en/w_addr/w_data sync write, r_en/r_addr/r_data read (async under SYNC_FIFO_FWFT_EN, registered otherwise)
module fifo_mem #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic [ADDR_SIZE-1:0] w_addr,
  input  logic [DATA_SIZE-1:0] w_data,
  input  logic                 r_en,
  input  logic [ADDR_SIZE-1:0] r_addr,
  output logic [DATA_SIZE-1:0] r_data
);
  logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];
  always_ff @(posedge clk)
    if (w_en) mem[w_addr] <= w_data;
`ifdef SYNC_FIFO_FWFT_EN
  logic unused_rd;
  assign unused_rd = rst ^ r_en;
  assign r_data = mem[r_addr];
`else
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_data <= '0;
    else if (r_en) r_data <= mem[r_addr];
`endif
endmodule

// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: single-clock FIFO with level, almost-full/empty and sticky overflow/underflow; ports clk, rst (active-low async), w_en/w_data/w_full/w_almost_full, r_en/r_data/r_empty/r_almost_empty, level, overflow, underflow; SYNC_FIFO_FWFT_EN selects zero-latency read
module sync_fifo_lvl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_SIZE  = 8,
  parameter int AFULL_THR  = 12,
  parameter int AEMPTY_THR = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic [DATA_SIZE-1:0] w_data,
  output logic                 w_full,
  output logic                 w_almost_full,
  input  logic                 r_en,
  output logic [DATA_SIZE-1:0] r_data,
  output logic                 r_empty,
  output logic                 r_almost_empty,
  output ptr_t                 level,
  output logic                 overflow,
  output logic                 underflow
);
  localparam ptr_t FULL_LVL   = ptr_t'(DEPTH);
  localparam ptr_t AFULL_LVL  = ptr_t'(AFULL_THR);
  localparam ptr_t AEMPTY_LVL = ptr_t'(AEMPTY_THR);
  ptr_t w_ptr, r_ptr, level_n;
  logic rd_acc, wr_acc;
  // a full FIFO still takes a write when the same edge pops a word
  always_comb begin
    rd_acc  = r_en && !r_empty;
    wr_acc  = w_en && (!w_full || rd_acc);
    level_n = level + ptr_t'(wr_acc) - ptr_t'(rd_acc);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      w_ptr          <= '0;
      r_ptr          <= '0;
      level          <= '0;
      w_full         <= 1'b0;
      w_almost_full  <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= next_ptr(w_ptr);
      if (rd_acc) r_ptr <= next_ptr(r_ptr);
      level          <= level_n;
      w_full         <= level_n == FULL_LVL;
      w_almost_full  <= level_n >= AFULL_LVL;
      r_empty        <= level_n == '0;
      r_almost_empty <= level_n <= AEMPTY_LVL;
      overflow       <= overflow | (w_en && !wr_acc);
      underflow      <= underflow | (r_en && !rd_acc);
    end
  fifo_mem #(.DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE)) u_mem (
    .clk    (clk),
    .rst    (rst),
    .w_en   (wr_acc),
    .w_addr (w_ptr[ADDR_SIZE-1:0]),
    .w_data (w_data),
    .r_en   (rd_acc),
    .r_addr (r_ptr[ADDR_SIZE-1:0]),
    .r_data (r_data)
  );
endmodule

// File: tb/tb_sync_fifo_lvl.sv
// tb_sync_fifo_lvl: randomized and directed bench for sync_fifo_lvl against a queue-based reference model
module tb_sync_fifo_lvl;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 0, w_en = 0, r_en = 0;
  logic [7:0] w_data = 0, r_data;
  logic w_full, w_almost_full, r_empty, r_almost_empty, overflow, underflow;
  logic [4:0] level;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  logic [7:0] m_rdata = 0;
  logic m_ovf = 0, m_unf = 0;
  sync_fifo_lvl dut (
    .clk(clk), .rst(rst), .w_en(w_en), .w_data(w_data), .w_full(w_full),
    .w_almost_full(w_almost_full), .r_en(r_en), .r_data(r_data), .r_empty(r_empty),
    .r_almost_empty(r_almost_empty), .level(level), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    int n = q.size();
    check("level", 32'(level), 32'(n));
    check("r_empty", 32'(r_empty), 32'(n == 0));
    check("w_full", 32'(w_full), 32'(n == DEPTH));
    check("w_almost_full", 32'(w_almost_full), 32'(n >= 12));
    check("r_almost_empty", 32'(r_almost_empty), 32'(n <= 2));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
    if (n != 0) check("r_data_fwft", 32'(r_data), 32'(q[0]));
`else
    check("r_data", 32'(r_data), 32'(m_rdata));
`endif
  endtask
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    logic rd, wr;
    @(negedge clk);
    w_en = w; w_data = d; r_en = r;
    rd = r && q.size() != 0;
    wr = w && (q.size() < DEPTH || rd);
    if (w && !wr) m_ovf = 1;
    if (r && !rd) m_unf = 1;
    if (rd) m_rdata = q.pop_front();
    if (wr) q.push_back(d);
    @(posedge clk);
    #1 check_all();
  endtask
  task automatic model_reset();
    q.delete(); m_rdata = 0; m_ovf = 0; m_unf = 0;
  endtask
  task automatic check_reset_outputs();
    check("rst_level", 32'(level), 0);
    check("rst_r_empty", 32'(r_empty), 1);
    check("rst_r_almost_empty", 32'(r_almost_empty), 1);
    check("rst_w_full", 32'(w_full), 0);
    check("rst_w_almost_full", 32'(w_almost_full), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_underflow", 32'(underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("rst_r_data", 32'(r_data), 0);
`endif
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 check_reset_outputs();
    @(negedge clk) rst = 1;
    step(0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0);
      check("afull_edge", 32'(w_almost_full), 32'(i >= 11));
    end
    check("full_after_16", 32'(w_full), 1);
    step(1, 8'hAA, 0);
    check("overflow_17th", 32'(overflow), 1);
    step(1, 8'h55, 1);
`ifndef SYNC_FIFO_FWFT_EN
    check("passthru_rdata", 32'(r_data), 0);
`endif
    check("passthru_level", 32'(level), 16);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1);
`ifndef SYNC_FIFO_FWFT_EN
      check("drain_seq", 32'(r_data), i < 15 ? 32'(i + 1) : 32'h55);
`endif
    end
    check("drained_empty", 32'(r_empty), 1);
    step(0, 0, 1);
    check("underflow_set", 32'(underflow), 1);
    step(1, 8'h3C, 1);
    check("empty_wr_rd_level", 32'(level), 1);
    step(0, 0, 1);
    for (int i = 0; i < 7; i++) step(1, 8'(8'h70 + i), 0);
    check("pre_rst_level", 32'(level), 7);
    @(negedge clk);
    w_en = 0; r_en = 0;
    #2 rst = 0;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk) rst = 1;
    step(1, 8'h99, 0);
    step(0, 0, 1);
`ifndef SYNC_FIFO_FWFT_EN
    check("post_rst_data", 32'(r_data), 32'h99);
`endif
    check("post_rst_level", 32'(level), 0);
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(0, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft_head", 32'(r_data), 32'h11);
    step(0, 0, 1);
    check("fwft_next", 32'(r_data), 32'h22);
    step(0, 0, 1);
    check("fwft_empty", 32'(r_empty), 1);
`else
    step(0, 0, 1);
    step(0, 0, 1);
`endif
    for (int p = 0; p < 6; p++) begin
      int wp = (p % 3 == 0) ? 80 : (p % 3 == 1) ? 20 : 50;
      for (int i = 0; i < 300; i++)
        step($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < 100 - wp);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
